// File: rtl/sram_rr_arbiter.sv
// sram_rr_arbiter: shares one asynchronous 16-bit SRAM between two Avalon-style
// masters (m0 = SOPC host, m1 = tester engine). One transfer is granted at a time,
// round-robin under contention, and CE/OE/WE/BE are sequenced with programmable
// wait states. Every transfer ends with one IDLE cycle that doubles as bus turnaround.
module sram_rr_arbiter #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16,
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 2
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   m0_address,
  input  logic [DATA_WIDTH/8-1:0] m0_byteenable,
  input  logic                    m0_read,
  input  logic                    m0_write,
  input  logic [DATA_WIDTH-1:0]   m0_writedata,
  output logic                    m0_waitrequest,
  output logic [DATA_WIDTH-1:0]   m0_readdata,
  output logic                    m0_readdatavalid,
  input  logic [ADDR_WIDTH-1:0]   m1_address,
  input  logic [DATA_WIDTH/8-1:0] m1_byteenable,
  input  logic                    m1_read,
  input  logic                    m1_write,
  input  logic [DATA_WIDTH-1:0]   m1_writedata,
  output logic                    m1_waitrequest,
  output logic [DATA_WIDTH-1:0]   m1_readdata,
  output logic                    m1_readdatavalid,
  output logic [ADDR_WIDTH-1:0]   sram_address,
  inout  wire  [DATA_WIDTH-1:0]   sram_data,
  output logic                    sram_ce_n,
  output logic                    sram_oe_n,
  output logic                    sram_we_n,
  output logic [DATA_WIDTH/8-1:0] sram_be_n
);

  localparam int BE_WIDTH  = DATA_WIDTH / 8;
  localparam int MAX_WAIT  = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
  localparam int CNT_WIDTH = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CNT_WIDTH-1:0] READ_CNT  = CNT_WIDTH'(READ_WAIT);
  localparam logic [CNT_WIDTH-1:0] WRITE_CNT = CNT_WIDTH'(WRITE_WAIT);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD      = 2'd1;
  localparam logic [1:0] WR      = 2'd2;
  localparam logic [1:0] WR_HOLD = 2'd3;

  logic [1:0]            state_reg, state_next;
  logic [CNT_WIDTH-1:0]  cnt_reg, cnt_next;
  logic                  grant_reg, grant_next;
  logic                  last_grant_reg, last_grant_next;
  logic [1:0]            req;
  logic                  pick;
  logic                  pick_write;
  logic                  accept;
  logic                  read_done;
  logic                  xfer_done;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [BE_WIDTH-1:0]   be_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [DATA_WIDTH-1:0] readdata_reg;
  logic [1:0]            rdv_reg;
  logic [1:0]            wait_vec;
  logic                  ce_n_reg, oe_n_reg, we_n_reg, drive_reg;

  assign req = {m1_read | m1_write, m0_read | m0_write};
  // Under contention the master that did not win last time goes first.
  assign pick       = (&req) ? ~last_grant_reg : req[1];
  // read+write together from one master is serviced as a write.
  assign pick_write = pick ? m1_write : m0_write;
  assign accept     = (state_reg == IDLE) && (|req);
  assign read_done  = (state_reg == RD) && (cnt_reg == '0);
  assign xfer_done  = read_done || (state_reg == WR_HOLD);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_wait
      assign wait_vec[gi] = ~(xfer_done && (grant_reg == 1'(gi)));
    end
  endgenerate

  // Next-state, wait-state counter and round-robin pointer.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          grant_next      = pick;
          last_grant_next = pick;
          if (pick_write) begin
            state_next = WR;
            cnt_next   = WRITE_CNT;
          end else begin
            state_next = RD;
            cnt_next   = READ_CNT;
          end
        end
      end
      RD: begin
        if (cnt_reg == '0) state_next = IDLE;
        else               cnt_next   = cnt_reg - 1'b1;
      end
      WR: begin
        if (cnt_reg == '0) state_next = WR_HOLD;
        else               cnt_next   = cnt_reg - 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Control registers; last_grant resets to m1 so m0 wins the first tie.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
    end
  end

  // Latch the granted command and capture read data on the last RD cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_reg     <= '0;
      be_reg       <= '0;
      wdata_reg    <= '0;
      readdata_reg <= '0;
      rdv_reg      <= 2'b00;
    end else begin
      if (accept) begin
        addr_reg  <= pick ? m1_address    : m0_address;
        be_reg    <= pick ? m1_byteenable : m0_byteenable;
        wdata_reg <= pick ? m1_writedata  : m0_writedata;
      end
      if (read_done) readdata_reg <= sram_data;
      rdv_reg <= {read_done && grant_reg, read_done && !grant_reg};
    end
  end

  // Strobes are registered from the next state so the pins never glitch.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ce_n_reg  <= 1'b1;
      oe_n_reg  <= 1'b1;
      we_n_reg  <= 1'b1;
      drive_reg <= 1'b0;
    end else begin
      ce_n_reg  <= (state_next == IDLE);
      oe_n_reg  <= (state_next != RD);
      we_n_reg  <= (state_next != WR);
      drive_reg <= (state_next == WR) || (state_next == WR_HOLD);
    end
  end

  assign sram_address     = addr_reg;
  assign sram_be_n        = ~be_reg;
  assign sram_ce_n        = ce_n_reg;
  assign sram_oe_n        = oe_n_reg;
  assign sram_we_n        = we_n_reg;
  assign sram_data        = drive_reg ? wdata_reg : {DATA_WIDTH{1'bz}};
  assign m0_waitrequest   = wait_vec[0];
  assign m1_waitrequest   = wait_vec[1];
  assign m0_readdata      = readdata_reg;
  assign m1_readdata      = readdata_reg;
  assign m0_readdatavalid = rdv_reg[0];
  assign m1_readdatavalid = rdv_reg[1];

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// tb_sram_rr_arbiter: directed and randomized transfers from both masters against a
// transaction-level model (grant order, cycle arithmetic, shadow memory).
module tb_sram_rr_arbiter;

  localparam int AW = 20;
  localparam int DW = 16;
  localparam int BW = DW / 8;
  localparam int RW = 2;
  localparam int WW = 2;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] addr_in [2];
  logic [BW-1:0] be_in [2];
  logic          rd_in [2];
  logic          wr_in [2];
  logic [DW-1:0] wd_in [2];

  wire           m0_waitrequest, m1_waitrequest;
  wire           m0_readdatavalid, m1_readdatavalid;
  wire [DW-1:0]  m0_readdata, m1_readdata;
  wire [AW-1:0]  sram_address;
  wire [DW-1:0]  sram_data;
  wire           sram_ce_n, sram_oe_n, sram_we_n;
  wire [BW-1:0]  sram_be_n;
  wire [1:0]     wait_v = {m1_waitrequest, m0_waitrequest};
  wire [1:0]     rdv_v  = {m1_readdatavalid, m0_readdatavalid};

  sram_rr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_WAIT(RW), .WRITE_WAIT(WW)) dut (
    .clock(clock), .reset_n(reset_n),
    .m0_address(addr_in[0]), .m0_byteenable(be_in[0]), .m0_read(rd_in[0]),
    .m0_write(wr_in[0]), .m0_writedata(wd_in[0]), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(addr_in[1]), .m1_byteenable(be_in[1]), .m1_read(rd_in[1]),
    .m1_write(wr_in[1]), .m1_writedata(wd_in[1]), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .sram_address(sram_address), .sram_data(sram_data), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Asynchronous SRAM device (256 words, low address bits decoded).
  logic [DW-1:0] dev_mem [256];
  logic [DW-1:0] img [256];
  logic          pl_all = 1'b0;
  always @(negedge clock) begin
    if (pl_all) begin
      for (int i = 0; i < 256; i++) dev_mem[i] <= img[i];
    end else if (!sram_ce_n && !sram_we_n) begin
      for (int k = 0; k < BW; k++)
        if (!sram_be_n[k]) dev_mem[sram_address[7:0]][8*k +: 8] <= sram_data[8*k +: 8];
    end
  end
  assign sram_data = (!sram_ce_n && !sram_oe_n && sram_we_n) ? dev_mem[sram_address[7:0]] : 16'hzzzz;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [DW-1:0] shadow [256];
  bit            last_model = 1'b1;
  logic [1:0]    s_op [2];   // 0 none, 1 read, 2 write, 3 read+write (acts as write)
  logic [AW-1:0] s_addr [2];
  logic [BW-1:0] s_be [2];
  logic [DW-1:0] s_wd [2];
  logic [DW-1:0] obs_rd [2];
  int            obs_order [$];

  task automatic set_m(input int m, input logic [1:0] op, input logic [AW-1:0] a,
                       input logic [BW-1:0] be, input logic [DW-1:0] wd);
    s_op[m] = op; s_addr[m] = a; s_be[m] = be; s_wd[m] = wd;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    return {12'($urandom), 1'b1, 7'($urandom)};
  endfunction

  task automatic model_xfer(input int m, output logic [DW-1:0] rd);
    int a;
    a  = int'(s_addr[m][7:0]);
    rd = shadow[a];
    if (s_op[m][1])
      for (int k = 0; k < BW; k++)
        if (s_be[m][k]) shadow[a][8*k +: 8] = s_wd[m][8*k +: 8];
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_wait"}, {30'd0, wait_v}, 32'd3);
    check({tag, "_rdv"}, {30'd0, rdv_v}, 32'd0);
    check({tag, "_rdata0"}, {16'd0, m0_readdata}, 32'd0);
    check({tag, "_rdata1"}, {16'd0, m1_readdata}, 32'd0);
    check({tag, "_strobes"}, {29'd0, sram_ce_n, sram_oe_n, sram_we_n}, 32'd7);
    check({tag, "_be_n"}, {30'd0, sram_be_n}, 32'd3);
    check({tag, "_data_z"}, {16'd0, sram_data}, {16'd0, 16'hzzzz});
  endtask

  // One arbitration round: every active master issues one command; expectations come
  // from the grant rule and fixed per-transfer cycle counts. Called just after a posedge.
  task automatic run_step();
    int   t0, first, second, own, ph, last_c;
    int   b [2];
    int   done_e [2];
    int   rdv_e [2];
    bit   act [2];
    bit   isw [2];
    logic [DW-1:0] rexp [2];
    logic e_ce, e_oe, e_we;
    t0 = cyc;
    for (int i = 0; i < 2; i++) begin
      act[i] = (s_op[i] != 2'd0);
      isw[i] = s_op[i][1];
      b[i] = isw[i] ? (WW + 2) : (RW + 1);
      done_e[i] = -1; rdv_e[i] = -1; rexp[i] = '0;
    end
    if (act[0] && act[1]) begin
      first = last_model ? 0 : 1;
      second = 1 - first;
    end else begin
      first = act[1] ? 1 : 0;
      second = -1;
    end
    done_e[first] = t0 + b[first];
    model_xfer(first, rexp[first]);
    last_model = (first == 1);
    if (second >= 0) begin
      done_e[second] = done_e[first] + 1 + b[second];
      model_xfer(second, rexp[second]);
      last_model = (second == 1);
    end
    last_c = t0;
    for (int i = 0; i < 2; i++) begin
      if (act[i] && !isw[i]) rdv_e[i] = done_e[i] + 1;
      if (done_e[i] > last_c) last_c = done_e[i];
      if (rdv_e[i] > last_c) last_c = rdv_e[i];
      addr_in[i] = s_addr[i]; be_in[i] = s_be[i]; wd_in[i] = s_wd[i];
      rd_in[i] = s_op[i][0]; wr_in[i] = s_op[i][1];
    end
    while (cyc <= last_c) begin
      @(negedge clock);
      for (int i = 0; i < 2; i++) begin
        check($sformatf("m%0d_waitrequest@t+%0d", i, cyc - t0), {31'd0, wait_v[i]},
              {31'd0, !(act[i] && cyc == done_e[i])});
        check($sformatf("m%0d_readdatavalid@t+%0d", i, cyc - t0), {31'd0, rdv_v[i]},
              {31'd0, cyc == rdv_e[i]});
        if (cyc == rdv_e[i]) begin
          obs_rd[i] = (i == 0) ? m0_readdata : m1_readdata;
          check($sformatf("m%0d_readdata", i), {16'd0, obs_rd[i]}, {16'd0, rexp[i]});
        end
        if (act[i] && wait_v[i] == 1'b0) obs_order.push_back(i);
      end
      own = -1; ph = 0;
      if (cyc > t0 && cyc <= done_e[first]) begin
        own = first; ph = cyc - t0 - 1;
      end else if (second >= 0 && cyc > done_e[first] + 1 && cyc <= done_e[second]) begin
        own = second; ph = cyc - done_e[first] - 2;
      end
      e_ce = 1'b1; e_oe = 1'b1; e_we = 1'b1;
      if (own >= 0) begin
        e_ce = 1'b0;
        if (isw[own]) e_we = (ph > WW);
        else          e_oe = 1'b0;
        check($sformatf("sram_address@t+%0d", cyc - t0), {12'd0, sram_address}, {12'd0, s_addr[own]});
        check($sformatf("sram_be_n@t+%0d", cyc - t0), {30'd0, sram_be_n}, {30'd0, ~s_be[own]});
        if (isw[own])
          check($sformatf("sram_data@t+%0d", cyc - t0), {16'd0, sram_data}, {16'd0, s_wd[own]});
      end
      check($sformatf("ce_oe_we@t+%0d", cyc - t0), {29'd0, sram_ce_n, sram_oe_n, sram_we_n},
            {29'd0, e_ce, e_oe, e_we});
      @(posedge clock);
      #1;
      for (int i = 0; i < 2; i++)
        if (act[i] && cyc - 1 == done_e[i]) begin
          rd_in[i] = 1'b0; wr_in[i] = 1'b0;
        end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_start;
    logic [1:0] op0, op1;
    for (int i = 0; i < 2; i++) begin
      addr_in[i] = '0; be_in[i] = '0; rd_in[i] = 1'b0; wr_in[i] = 1'b0; wd_in[i] = '0;
      set_m(i, 2'd0, '0, '0, '0);
      obs_rd[i] = '0;
    end
    for (int i = 0; i < 256; i++) begin
      img[i] = 16'($urandom);
      shadow[i] = img[i];
    end
    img[8'h10] = 16'hBEEF; shadow[8'h10] = 16'hBEEF;
    img[8'h20] = 16'h1234; shadow[8'h20] = 16'h1234;
    img[8'h30] = 16'h0F0F; shadow[8'h30] = 16'h0F0F;
    pl_all = 1'b1;
    @(negedge clock);
    #1 pl_all = 1'b0;

    // Reset state, during and after reset
    check_idle("reset");
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check_idle("post_reset");

    // Contention from reset: alternating grant order
    obs_order.delete();
    repeat (4) begin
      set_m(0, 2'd1, rnd_addr(), 2'b11, '0);
      set_m(1, 2'd1, rnd_addr(), 2'b11, '0);
      run_step();
    end
    check("rr_order_count", obs_order.size(), 32'd8);
    for (int k = 0; k < obs_order.size(); k++)
      check($sformatf("rr_order[%0d]", k), obs_order[k], k % 2);

    // Single m0 read of a known word
    set_m(0, 2'd1, 20'h00010, 2'b11, '0);
    set_m(1, 2'd0, '0, '0, '0);
    run_step();
    check("t1_readdata_beef", {16'd0, obs_rd[0]}, 32'h0000BEEF);

    // m1 byte-lane write, then m0 readback
    set_m(1, 2'd2, 20'h00020, 2'b01, 16'hA5A5);
    set_m(0, 2'd0, '0, '0, '0);
    run_step();
    set_m(0, 2'd1, 20'h00020, 2'b11, '0);
    set_m(1, 2'd0, '0, '0, '0);
    run_step();
    check("t2_readback", {16'd0, obs_rd[0]}, 32'h000012A5);

    // m0 back-to-back writes, 5 cycles each
    t_start = cyc;
    repeat (3) begin
      set_m(0, 2'd2, rnd_addr(), 2'($urandom), 16'($urandom));
      set_m(1, 2'd0, '0, '0, '0);
      run_step();
    end
    check("t4_span", cyc - t_start, 32'd15);

    // read+write together is a write
    set_m(0, 2'd3, 20'h00030, 2'b11, 16'h5555);
    set_m(1, 2'd0, '0, '0, '0);
    run_step();
    set_m(0, 2'd1, 20'h00030, 2'b11, '0);
    run_step();
    check("t6_readback", {16'd0, obs_rd[0]}, 32'h00005555);

    // Asynchronous reset in the middle of a write
    addr_in[0] = 20'h00040; be_in[0] = 2'b11; wd_in[0] = 16'h3C3C; wr_in[0] = 1'b1;
    @(posedge clock);
    #1;
    @(negedge clock);
    check("t5_we_low_before_reset", {31'd0, sram_we_n}, 32'd0);
    #1;
    reset_n = 1'b0;
    wr_in[0] = 1'b0;
    #1;
    check_idle("t5_async");
    last_model = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    set_m(0, 2'd1, 20'h00010, 2'b11, '0);
    set_m(1, 2'd1, 20'h00020, 2'b11, '0);
    run_step();
    check("t5_m0_read", {16'd0, obs_rd[0]}, 32'h0000BEEF);
    check("t5_m1_read", {16'd0, obs_rd[1]}, 32'h000012A5);

    // Randomized mixes of both masters
    repeat (40) begin
      op0 = 2'($urandom_range(0, 3));
      op1 = 2'($urandom_range(0, 3));
      if (op0 == 2'd0 && op1 == 2'd0) op0 = 2'd1;
      set_m(0, op0, rnd_addr(), 2'($urandom), 16'($urandom));
      set_m(1, op1, rnd_addr(), 2'($urandom), 16'($urandom));
      run_step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
